// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Multi-channel byte-serial RAM/IO controller. NUM_CH requesters share one
//   8-bit external memory bus. Each transaction moves 1/2/4/LINE_BYTES bytes
//   at consecutive addresses. Reads are sign- or zero-extended (byte/half).
//   The controller stalls on UART back-pressure and aborts reads on a ROB flush.
//
// Configuration macro:
//   ROUND_ROBIN_EN  defined  -> round-robin grant, starting after the last
//                               granted channel (channel 0 wins first)
//                   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   rdy_in               global enable; low freezes every register
//   rob_clear            flush: cancels reads in flight, never writes
//   req/req_wr/req_size/req_signed/req_addr/req_wdata
//                        per-channel request level and transfer fields
//   done                 one-cycle one-hot completion pulse
//   rdata                read data, valid while done is high
//   busy                 transaction in flight
//   mem_din/mem_dout/mem_a/mem_wr   external byte bus (read data one cycle late)
//   io_buffer_full       UART buffer full, stalls IO-space transfers

module mem_port_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int LINE_BYTES = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           rob_clear,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH-1:0]              req_wr,
  input  logic [2*NUM_CH-1:0]            req_size,
  input  logic [NUM_CH-1:0]              req_signed,
  input  logic [32*NUM_CH-1:0]           req_addr,
  input  logic [8*LINE_BYTES*NUM_CH-1:0] req_wdata,
  output logic [NUM_CH-1:0]              done,
  output logic [8*LINE_BYTES-1:0]        rdata,
  output logic                           busy,
  input  logic [7:0]                     mem_din,
  output logic [7:0]                     mem_dout,
  output logic [31:0]                    mem_a,
  output logic                           mem_wr,
  input  logic                           io_buffer_full
);

  localparam int LW    = 8 * LINE_BYTES;
  localparam int IDX_W = $clog2(LINE_BYTES);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       addr_q, addr_d;
  logic [LW-1:0]     wdata_q, wdata_d;
  logic [LW-1:0]     buf_q, buf_d;
  logic              cap_vld_q, cap_vld_d;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              busy_q, busy_d;
  logic [LW-1:0]     rdata_q, rdata_d;
`ifdef ROUND_ROBIN_EN
  logic [CH_W-1:0]   ptr_q, ptr_d;
`endif

  logic              stall;
  logic              issue;
  logic [IDX_W-1:0]  last_idx;
  logic [NUM_CH-1:0] elig;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic [LW-1:0]     ext;

  // IO space (addr[17:16]==11) holds the bus idle while the UART is full.
  assign stall = (state_q == XFER) && (addr_q[17:16] == 2'b11) && io_buffer_full;
  assign issue = (state_q == XFER) && !stall;

  assign mem_a    = issue ? (addr_q + 32'(idx_q)) : 32'h0;
  assign mem_wr   = issue && wr_q && rdy_in;
  assign mem_dout = issue ? wdata_q[8*int'(idx_q) +: 8] : 8'h0;

  assign done  = done_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

  always_comb begin
    case (size_q)
      2'b00:   last_idx = '0;
      2'b01:   last_idx = IDX_W'(1);
      2'b10:   last_idx = IDX_W'(3);
      default: last_idx = IDX_W'(LINE_BYTES - 1);
    endcase
  end

  // A flush in IDLE blocks new reads but still lets writes through.
  always_comb begin
    elig    = req & (req_wr | {NUM_CH{~rob_clear}});
    gnt_vld = 1'b0;
    gnt_ch  = '0;
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (int'(ptr_q) + k) % NUM_CH;
      if (!gnt_vld && elig[c]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(c);
      end
    end
`else
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(i);
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ch_d      = ch_q;
    wr_d      = wr_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
    done_d    = '0;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    ext       = '0;
`ifdef ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif

    // Read bytes arrive one cycle after their address; a capture issued
    // before a stall or flush still lands.
    if (cap_vld_q) begin
      buf_d[8*int'(cap_idx_q) +: 8] = mem_din;
    end

    case (state_q)
      IDLE: begin
        // The completion cycle is a turnaround: the finishing requester
        // still has req high, so nothing is granted while done is asserted.
        if (gnt_vld && (done_q == '0)) begin
          ch_d    = gnt_ch;
          wr_d    = req_wr[gnt_ch];
          size_d  = req_size[2*int'(gnt_ch) +: 2];
          sgn_d   = req_signed[gnt_ch];
          addr_d  = req_addr[32*int'(gnt_ch) +: 32];
          wdata_d = req_wdata[LW*int'(gnt_ch) +: LW];
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = XFER;
`ifdef ROUND_ROBIN_EN
          ptr_d   = gnt_ch;
`endif
        end
      end
      XFER: begin
        if (!wr_q && rob_clear) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (!stall) begin
          if (!wr_q) begin
            cap_vld_d = 1'b1;
            cap_idx_d = idx_q;
          end
          if (idx_q == last_idx) begin
            if (wr_q) begin
              state_d      = IDLE;
              busy_d       = 1'b0;
              done_d[ch_q] = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!rob_clear) begin
          case (size_q)
            2'b00:   ext[31:0] = {{24{sgn_q & buf_d[7]}}, buf_d[7:0]};
            2'b01:   ext[31:0] = {{16{sgn_q & buf_d[15]}}, buf_d[15:0]};
            2'b10:   ext[31:0] = buf_d[31:0];
            default: ext       = buf_d;
          endcase
          rdata_d      = ext;
          done_d[ch_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state freezes while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ch_q      <= '0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      sgn_q     <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= '0;
      buf_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= CH_W'(NUM_CH - 1);
`endif
    end else if (rdy_in) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

endmodule
